// File: rtl/mem_access.sv
// mem_access: MIPS32 memory stage.
// Takes execute results, runs a two-phase data-bus transaction for loads and
// stores (byte/half lane steering, strobes, load extension) and hands the
// write-back value downstream over a valid/ready handshake.
module mem_access #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rd,
   input  logic [ADDR_W-1:0] in_value,
   input  logic [ADDR_W-1:0] in_vt,
   input  logic              in_load,
   input  logic              in_store,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_rd,
   output logic [ADDR_W-1:0] out_value,
   output logic              out_misalign,
   output logic              dreq_valid,
   output logic [ADDR_W-1:0] dreq_addr,
   output logic [1:0]        dreq_size,
   output logic [3:0]        dreq_strobe,
   output logic [ADDR_W-1:0] dreq_data,
   input  logic              dresp_addr_ok,
   input  logic              dresp_data_ok,
   input  logic [ADDR_W-1:0] dresp_data
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]        r_state;
   logic [4:0]        r_rd;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_vt;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic              r_store;
   logic [4:0]        r_outRd;
   logic [ADDR_W-1:0] r_outValue;
   logic              r_misalign;

   logic              w_inMem;
   logic              w_inMisalign;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [ADDR_W-1:0] w_loadValue;
   logic [3:0]        w_strobe;
   logic [ADDR_W-1:0] w_storeData;
   logic              w_capture;

   // Classify the incoming op: memory access, and whether its address is unaligned for its size
   always_comb begin
      w_inMem      = in_load | in_store;
      w_inMisalign = 1'b0;
      if (w_inMem) begin
         if (in_size == 2'd1)
            w_inMisalign = in_value[0];
         else if (in_size == 2'd2)
            w_inMisalign = (in_value[1:0] != 2'b00);
      end
   end

   // Pick the addressed lane out of the returned word and sign/zero-extend it
   always_comb begin
      w_byte = 8'h00;
      case (r_addr[1:0])
         2'd0: w_byte = dresp_data[7:0];
         2'd1: w_byte = dresp_data[15:8];
         2'd2: w_byte = dresp_data[23:16];
         default: w_byte = dresp_data[31:24];
      endcase
      w_half = r_addr[1] ? dresp_data[31:16] : dresp_data[15:0];
      case (r_size)
         2'd0: w_loadValue = {{(ADDR_W-8){~r_unsigned & w_byte[7]}}, w_byte};
         2'd1: w_loadValue = {{(ADDR_W-16){~r_unsigned & w_half[15]}}, w_half};
         default: w_loadValue = dresp_data;
      endcase
   end

   // Byte enables and lane-replicated write data; loads never write any lane
   always_comb begin
      w_strobe    = 4'b0000;
      w_storeData = r_vt;
      case (r_size)
         2'd0: begin
            w_strobe    = 4'b0001 << r_addr[1:0];
            w_storeData = {4{r_vt[7:0]}};
         end
         2'd1: begin
            w_strobe    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_storeData = {2{r_vt[15:0]}};
         end
         default: begin
            w_strobe    = 4'b1111;
            w_storeData = r_vt;
         end
      endcase
      if (!r_store)
         w_strobe = 4'b0000;
   end

   // Response data is taken when data_ok arrives in WAIT, or together with addr_ok in REQ
   always_comb begin
      w_capture = 1'b0;
      if (r_state == S_REQ)
         w_capture = dresp_addr_ok & dresp_data_ok;
      else if (r_state == S_WAIT)
         w_capture = dresp_data_ok;
   end

   // Stage sequencing: accept, request, wait for completion, hold the result until taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rd       <= '0;
         r_addr     <= '0;
         r_vt       <= '0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_store    <= 1'b0;
         r_outRd    <= '0;
         r_outValue <= '0;
         r_misalign <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_rd       <= in_rd;
                  r_addr     <= in_value;
                  r_vt       <= in_vt;
                  r_size     <= in_size;
                  r_unsigned <= in_unsigned;
                  r_store    <= in_store;
                  r_misalign <= w_inMisalign;
                  if (!w_inMem) begin
                     r_outRd    <= in_rd;
                     r_outValue <= in_value;
                     r_state    <= S_HOLD;
                  end else if (w_inMisalign) begin
                     r_outRd    <= '0;
                     r_outValue <= in_value;
                     r_state    <= S_HOLD;
                  end else begin
                     r_state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (dresp_addr_ok)
                  r_state <= dresp_data_ok ? S_HOLD : S_WAIT;
            end
            S_WAIT: begin
               if (dresp_data_ok)
                  r_state <= S_HOLD;
            end
            default: begin
               if (out_ready)
                  r_state <= S_IDLE;
            end
         endcase
         if (w_capture) begin
            r_outRd    <= r_store ? 5'd0 : r_rd;
            r_outValue <= r_store ? '0 : w_loadValue;
         end
      end
   end

   // Handshake and bus outputs are decoded from the state; fields read as zero outside their phase
   always_comb begin
      in_ready     = (r_state == S_IDLE);
      out_valid    = (r_state == S_HOLD);
      out_rd       = out_valid ? r_outRd : '0;
      out_value    = out_valid ? r_outValue : '0;
      out_misalign = out_valid & r_misalign;
      dreq_valid   = (r_state == S_REQ);
      dreq_addr    = dreq_valid ? r_addr : '0;
      dreq_size    = dreq_valid ? r_size : '0;
      dreq_strobe  = dreq_valid ? w_strobe : '0;
      dreq_data    = dreq_valid ? w_storeData : '0;
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of the memory stage against
// an arithmetic reference model of lane selection, strobes and extension.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_value, in_vt;
   logic        in_load, in_store, in_unsigned;
   logic [1:0]  in_size;
   logic        out_valid, out_ready;
   logic [4:0]  out_rd;
   logic [31:0] out_value;
   logic        out_misalign;
   logic        dreq_valid;
   logic [31:0] dreq_addr, dreq_data;
   logic [1:0]  dreq_size;
   logic [3:0]  dreq_strobe;
   logic        dresp_addr_ok, dresp_data_ok;
   logic [31:0] dresp_data;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  strobe;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] value;
      logic        mis;
      bit          bus;
   } expT;

   always #5 clk = ~clk;

   mem_access #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
      .in_value(in_value), .in_vt(in_vt), .in_load(in_load),
      .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_value(out_value), .out_misalign(out_misalign),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
      .dresp_data(dresp_data)
   );

   // Reference model built from plain arithmetic on byte offsets
   function automatic expT refModel(input bit ld, input bit st, input int sz, input bit uns,
                                    input logic [4:0] rd, input logic [31:0] addr,
                                    input logic [31:0] vt, input logic [31:0] busWord);
      expT e;
      int unsigned off;
      logic [31:0] v;
      off = addr % 4;
      e.strobe = 4'd0;
      e.wdata  = 32'd0;
      e.rd     = rd;
      e.value  = addr;
      e.mis    = 1'b0;
      e.bus    = 1'b0;
      if (ld || st) begin
         e.mis = ((sz == 1) && (addr % 2 != 0)) || ((sz == 2) && (off != 0));
         if (e.mis) begin
            e.rd = 5'd0;
         end else begin
            e.bus = 1'b1;
            if (st) begin
               e.rd    = 5'd0;
               e.value = 32'd0;
               if (sz == 0) begin
                  e.strobe = 4'(1 << off);
                  e.wdata  = (vt % 256) * 32'h01010101;
               end else if (sz == 1) begin
                  e.strobe = 4'(3 << off);
                  e.wdata  = (vt % 65536) * 32'h00010001;
               end else begin
                  e.strobe = 4'd15;
                  e.wdata  = vt;
               end
            end else begin
               if (sz == 0) begin
                  v = (busWord >> (8 * off)) % 256;
                  if (!uns && v >= 128) v = v + 32'hFFFFFF00;
               end else if (sz == 1) begin
                  v = (busWord >> (16 * (off / 2))) % 65536;
                  if (!uns && v >= 32768) v = v + 32'hFFFF0000;
               end else begin
                  v = busWord;
               end
               e.value = v;
            end
         end
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete op: accept, bus phases with chosen delays, hold, release
   task automatic applyStimulus(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                                input logic [4:0] rd, input logic [31:0] addr,
                                input logic [31:0] vt, input logic [31:0] busWord,
                                input int addrDelay, input int dataDelay, input int holdDelay);
      expT e;
      e = refModel(ld, st, int'(sz), uns, rd, addr, vt, busWord);
      @(negedge clk);
      checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz;
      in_unsigned = uns; in_rd = rd; in_value = addr; in_vt = vt;
      @(negedge clk);
      in_valid = 1'b0; in_value = $urandom; in_vt = $urandom; in_rd = 5'($urandom);
      if (e.bus) begin
         for (int i = 0; i <= addrDelay; i++) begin
            checkOutput("req_valid", 32'(dreq_valid), 32'd1);
            checkOutput("req_addr", dreq_addr, addr);
            checkOutput("req_size", 32'(dreq_size), 32'(sz));
            checkOutput("req_strobe", 32'(dreq_strobe), 32'(e.strobe));
            if (st) checkOutput("req_data", dreq_data, e.wdata);
            checkOutput("req_in_ready", 32'(in_ready), 32'd0);
            checkOutput("req_out_valid", 32'(out_valid), 32'd0);
            if (i < addrDelay) begin
               dresp_data_ok = 1'($urandom);
               dresp_data = $urandom;
            end else begin
               dresp_addr_ok = 1'b1;
               dresp_data_ok = (dataDelay == 0);
               dresp_data = (dataDelay == 0) ? busWord : $urandom;
            end
            @(negedge clk);
            dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
         end
         if (dataDelay > 0) begin
            for (int j = 1; j <= dataDelay; j++) begin
               checkOutput("wait_req_valid", 32'(dreq_valid), 32'd0);
               checkOutput("wait_out_valid", 32'(out_valid), 32'd0);
               dresp_data_ok = (j == dataDelay);
               dresp_data = (j == dataDelay) ? busWord : $urandom;
               @(negedge clk);
               dresp_data_ok = 1'b0;
            end
         end
      end
      dresp_data = $urandom;
      for (int k = 0; k <= holdDelay; k++) begin
         checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_out_rd", 32'(out_rd), 32'(e.rd));
         checkOutput("hold_out_value", out_value, e.value);
         checkOutput("hold_misalign", 32'(out_misalign), 32'(e.mis));
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
         checkOutput("hold_req_valid", 32'(dreq_valid), 32'd0);
         out_ready = (k == holdDelay);
         @(negedge clk);
      end
      out_ready = 1'b0;
      checkOutput("release_out_valid", 32'(out_valid), 32'd0);
      checkOutput("release_in_ready", 32'(in_ready), 32'd1);
   endtask

   // Linear directed sequence followed by randomized ops
   initial begin
      reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_value = '0; in_vt = '0;
      in_load = 1'b0; in_store = 1'b0; in_size = '0; in_unsigned = 1'b0;
      out_ready = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_rd", 32'(out_rd), 32'd0);
      checkOutput("rst_out_value", out_value, 32'd0);
      checkOutput("rst_misalign", 32'(out_misalign), 32'd0);
      checkOutput("rst_req_valid", 32'(dreq_valid), 32'd0);
      checkOutput("rst_req_strobe", 32'(dreq_strobe), 32'd0);
      reset = 1'b0;

      applyStimulus(0, 0, 2'd0, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 0);
      applyStimulus(1, 0, 2'd0, 0, 5'd7, 32'h1003, 32'h0, 32'h80123456, 1, 2, 0);
      applyStimulus(1, 0, 2'd0, 1, 5'd7, 32'h1003, 32'h0, 32'h80123456, 1, 2, 0);
      applyStimulus(0, 1, 2'd1, 0, 5'd9, 32'h2002, 32'hDEADBEEF, 32'h0, 0, 0, 0);
      applyStimulus(1, 0, 2'd2, 0, 5'd3, 32'h3001, 32'h0, 32'h0, 0, 0, 0);
      applyStimulus(1, 1, 2'd0, 0, 5'd4, 32'h4001, 32'h000000A5, 32'h0, 0, 1, 0);
      applyStimulus(1, 0, 2'd1, 0, 5'd6, 32'h5002, 32'h0, 32'h9ABC1234, 5, 1, 3);
      applyStimulus(0, 1, 2'd2, 0, 5'd8, 32'h6004, 32'h11223344, 32'h0, 5, 0, 3);

      // Reset asserted while the stage is waiting for data_ok
      @(negedge clk);
      in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd2;
      in_value = 32'h7000; in_rd = 5'd12;
      @(negedge clk);
      in_valid = 1'b0;
      dresp_addr_ok = 1'b1;
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      checkOutput("pre_rst_wait_req", 32'(dreq_valid), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("midrst_req_valid", 32'(dreq_valid), 32'd0);
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      dresp_data_ok = 1'b1; dresp_data = 32'hCAFEF00D;
      @(negedge clk);
      dresp_data_ok = 1'b0;
      checkOutput("late_data_out_valid", 32'(out_valid), 32'd0);
      checkOutput("late_data_in_ready", 32'(in_ready), 32'd1);

      for (int n = 0; n < 60; n++) begin
         int kind;
         bit ld, st;
         logic [1:0] sz;
         kind = int'($urandom_range(0, 4));
         ld = (kind == 1) || (kind == 2) || (kind == 4);
         st = (kind == 3) || (kind == 4);
         sz = (kind == 0) ? 2'd0 : 2'($urandom_range(0, 2));
         applyStimulus(ld, st, sz, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
